// File: rtl/partsel_pkg.sv
// Shared types and range helpers for the part-select chunk packer.
package partsel_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

    function automatic int lo_idx(int msb, int lsb);
        return (msb < lsb) ? msb : lsb;
    endfunction

    function automatic int width(int msb, int lsb);
        return (msb < lsb) ? (lsb - msb + 1) : (msb - lsb + 1);
    endfunction

    // A single-slot word still needs a one-bit slot index.
    function automatic int slot_bits(int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/partsel_up_insert.sv
// Combinational slot insert: returns word with word[LO + slot*CHUNK +: CHUNK] replaced by chunk.
module partsel_up_insert
    import partsel_pkg::*;
#(
    parameter int MSB   = 7,
    parameter int LSB   = 0,
    parameter int CHUNK = 2,
    parameter int SW    = 2
) (
    input  logic [MSB:LSB]    word,
    input  logic [SW-1:0]     slot,
    input  logic [CHUNK-1:0]  chunk,
    output logic [MSB:LSB]    result
);

    localparam int LO = lo_idx(MSB, LSB);

    int base;

    // Ascending select on the declared range: for a big-endian word the
    // lowest-numbered bit of the slot is the most significant one.
    always_comb begin
        base   = LO + int'(slot) * CHUNK;
        result = word;
        result[base +: CHUNK] = chunk;
    end

endmodule

// File: rtl/partsel_up_packer.sv
// Streaming chunk-to-word packer over a [MSB:LSB] word of either endianness.
// Optional shadow self-check: define PARTSEL_PACKER_CHECK_EN.
module partsel_up_packer
    import partsel_pkg::*;
#(
    parameter int MSB   = 7,
    parameter int LSB   = 0,
    parameter int CHUNK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHUNK-1:0]  in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MSB:LSB]    out_data
);

    localparam int N     = width(MSB, LSB);
    localparam int SLOTS = N / CHUNK;
    localparam int SW    = slot_bits(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    generate
        if ((N % CHUNK) != 0) begin : g_bad_chunk
            $error("partsel_up_packer: word width must be a multiple of CHUNK");
        end
    endgenerate

    packer_state_e   state_p0, state_nxt;
    logic [SW-1:0]   cnt_p0, cnt_nxt;
    logic [MSB:LSB]  word_p0, word_nxt;

    logic            accept;
    logic            ins_last_slot;
    logic [MSB:LSB]  ins_base;
    logic [SW-1:0]   ins_slot;
    logic [MSB:LSB]  ins_word;

    assign accept = in_valid && in_ready;

    // A chunk taken while draining starts a fresh, all-zero word at slot 0.
    assign ins_base      = (state_p0 == HOLD) ? '0 : word_p0;
    assign ins_slot      = (state_p0 == HOLD) ? '0 : cnt_p0;
    assign ins_last_slot = (ins_slot == LAST_SLOT);

    partsel_up_insert #(
        .MSB   (MSB),
        .LSB   (LSB),
        .CHUNK (CHUNK),
        .SW    (SW)
    ) u_insert (
        .word   (ins_base),
        .slot   (ins_slot),
        .chunk  (in_data),
        .result (ins_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= FILL;
            cnt_p0   <= '0;
            word_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            word_p0  <= word_nxt;
        end
    end

    // Next-state
    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        word_nxt  = word_p0;
        case (state_p0)
            FILL: begin
                if (accept) begin
                    word_nxt = ins_word;
                    if (ins_last_slot || in_last) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_p0 + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        word_nxt = ins_word;
                        if (ins_last_slot || in_last) begin
                            state_nxt = HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = FILL;
                            cnt_nxt   = SW'(1);
                        end
                    end else begin
                        state_nxt = FILL;
                        cnt_nxt   = '0;
                        word_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
                cnt_nxt   = '0;
                word_nxt  = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = (state_p0 == HOLD);
        in_ready  = (state_p0 != HOLD) || out_ready;
        out_data  = word_p0;
    end

`ifdef PARTSEL_PACKER_CHECK_EN
    localparam int LO = lo_idx(MSB, LSB);

    logic [MSB:LSB] shadow_p0, shadow_nxt;
    int             sbase;

    // Independent per-bit rebuild of the word, compared against the part-select path.
    always_comb begin
        shadow_nxt = shadow_p0;
        sbase      = LO + int'(ins_slot) * CHUNK;
        if ((state_p0 == HOLD) && out_ready) begin
            shadow_nxt = '0;
        end
        if (accept) begin
            for (int i = 0; i < CHUNK; i++) begin
                shadow_nxt[sbase + i] = in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_p0 <= '0;
        end else begin
            shadow_p0 <= shadow_nxt;
        end
        if (!rst) begin
            assert (shadow_p0 === out_data);
        end
    end
`endif

endmodule

// File: tb/tb_partsel_up_packer.sv
// Bench for partsel_up_packer: little-endian offset, big-endian, and single-slot instances.
`timescale 1ns/1ps
module tb_partsel_up_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_last, out_ready;
    logic [1:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [5:-2] a_out_data;
    logic        b_in_ready, b_out_valid;
    logic [2:9]  b_out_data;

    logic       c_in_valid, c_in_last, c_out_ready, c_in_ready, c_out_valid;
    logic [7:0] c_in_data;
    logic [0:7] c_out_data;

    partsel_up_packer #(.MSB(5), .LSB(-2), .CHUNK(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data)
    );

    partsel_up_packer #(.MSB(2), .LSB(9), .CHUNK(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data)
    );

    partsel_up_packer #(.MSB(0), .LSB(7), .CHUNK(8)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a word is the list of accepted chunks; slot k sits at numeric
    // offset 2k (little-endian) or 8-2(k+1) (big-endian) of the 8-bit value.
    bit         m_valid;
    logic [7:0] m_le, m_be;
    logic [1:0] q[$];

    function automatic logic [7:0] pack_le();
        logic [7:0] v = 8'h00;
        foreach (q[k]) v = v | (8'(q[k]) << (2 * k));
        return v;
    endfunction

    function automatic logic [7:0] pack_be();
        logic [7:0] v = 8'h00;
        foreach (q[k]) v = v | (8'(q[k]) << (8 - 2 * (k + 1)));
        return v;
    endfunction

    task automatic model_step();
        bit rdy;
        if (rst) begin
            m_valid = 1'b0;
            q.delete();
            m_le = 8'h00;
            m_be = 8'h00;
        end else begin
            rdy = !m_valid || out_ready;
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_le    = 8'h00;
                m_be    = 8'h00;
            end
            if (in_valid && rdy) begin
                q.push_back(in_data);
                m_le = pack_le();
                m_be = pack_be();
                if (q.size() == 4 || in_last) begin
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("a_out_valid", 32'(a_out_valid), 32'(m_valid));
        chk("a_out_data",  32'(a_out_data),  32'(m_le));
        chk("a_in_ready",  32'(a_in_ready),  32'(!m_valid || out_ready));
        chk("b_out_valid", 32'(b_out_valid), 32'(m_valid));
        chk("b_out_data",  32'(b_out_data),  32'(m_be));
        chk("b_in_ready",  32'(b_in_ready),  32'(!m_valid || out_ready));
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic       l;
        logic       r;
        logic       ev;
        logic       erdy;
        logic [7:0] ele;
        logic [7:0] ebe;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h40};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h60};
        tbl[2]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h39, 8'h6C};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h39, 8'h6C};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'hC0};
        tbl[6]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 8'hE0};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 8'hE0};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 8'hE0};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 8'hE0};
        tbl[10] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'hC0};
        tbl[11] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'hC0};
        tbl[12] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h40};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h60};
        tbl[14] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h39, 8'h6C};
        tbl[15] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h39, 8'h6C};
        tbl[16] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'hC0};

        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        c_in_valid = 1'b0; c_in_data = 8'h00; c_in_last = 1'b0; c_out_ready = 1'b0;
        m_valid = 1'b0; m_le = 8'h00; m_be = 8'h00;

        cycle();
        cycle();
        chk("reset_valid", 32'(a_out_valid), 32'd0);
        chk("reset_data",  32'(a_out_data),  32'd0);
        chk("reset_ready", 32'(a_in_ready),  32'd1);
        rst = 1'b0;

        // Directed vectors: full words, zero-padding, backpressure, drain+accept
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            cycle();
            chk($sformatf("tbl%0d_valid", i), 32'(a_out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_ready", i), 32'(a_in_ready),  32'(tbl[i].erdy));
            chk($sformatf("tbl%0d_le", i),    32'(a_out_data),  32'(tbl[i].ele));
            chk($sformatf("tbl%0d_be", i),    32'(b_out_data),  32'(tbl[i].ebe));
        end

        // Reset with a partial word in flight, then check for residue
        drive(1'b1, 2'b11, 1'b0, 1'b1);
        cycle();
        rst = 1'b1;
        cycle();
        chk("midrst_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_data",  32'(a_out_data),  32'd0);
        chk("midrst_ready", 32'(a_in_ready),  32'd1);
        rst = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        cycle();
        chk("postrst_le", 32'(a_out_data), 32'h01);
        chk("postrst_be", 32'(b_out_data), 32'h40);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 1'b0, 1'b1);
            cycle();
        end
        chk("clean_valid", 32'(a_out_valid), 32'd1);
        chk("clean_le",    32'(a_out_data),  32'hAA);
        chk("clean_be",    32'(b_out_data),  32'hAA);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 2'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 80) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b1);

        // Single-slot word: back-to-back words with no bubble
        c_in_valid = 1'b1; c_in_data = 8'hA5; c_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("c%0d_valid", i), 32'(c_out_valid), 32'd1);
            chk($sformatf("c%0d_data", i),  32'(c_out_data),  32'hA5);
            chk($sformatf("c%0d_ready", i), 32'(c_in_ready),  32'd1);
        end
        c_in_data = 8'h3C; c_out_ready = 1'b0;
        cycle();
        chk("c_hold_valid", 32'(c_out_valid), 32'd1);
        chk("c_hold_data",  32'(c_out_data),  32'hA5);
        chk("c_hold_ready", 32'(c_in_ready),  32'd0);
        c_out_ready = 1'b1;
        cycle();
        chk("c_next_data",  32'(c_out_data),  32'h3C);
        c_in_valid = 1'b0;
        cycle();
        chk("c_drain_valid", 32'(c_out_valid), 32'd0);
        chk("c_drain_data",  32'(c_out_data),  32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
